rename_register_file: RTL and testbench
=======================================

// Module: rename_register_file
// PURPOSE
//  Architectural register file with per-register rename tags for the Tomasulo core.
//  Receiving end of the reorder buffer commit interface: retires committed results into x1..x31.
//  On the decoder side, records rd -> ROB-tag renames at issue.
//  Also serves rs1/rs2 operands to the decoder as either a ready value (Q = NULL) or a pending ROB tag.
// PARAMETERS
//  REG_COUNT   32  number of architectural registers; x0 hardwired to zero
//  REG_IDX_W   5   register index width
//  TAG_W       4   ROB tag width; tag 0 = NULL (no producer), valid tags 1..15
//  DATA_W      32  register data width
// PORTS
//  clk                   in   1        clock, all state updates on posedge
//  rst                   in   1        synchronous active-high reset
//  dec_rs1_in            in   REG_IDX_W  source register 1 index (combinational read)
//  dec_rs2_in            in   REG_IDX_W  source register 2 index (combinational read)
//  dec_Vj_out            out  DATA_W   value of rs1 (meaningful when dec_Qj_out == NULL)
//  dec_Vk_out            out  DATA_W   value of rs2 (meaningful when dec_Qk_out == NULL)
//  dec_Qj_out            out  TAG_W    pending producer tag of rs1, NULL if value ready
//  dec_Qk_out            out  TAG_W    pending producer tag of rs2, NULL if value ready
//  dec_issue_signal_in   in   1        an instruction with a destination issues this cycle
//  dec_rd_in             in   REG_IDX_W  destination register of issuing instruction
//  dec_tag_in            in   TAG_W    ROB tag allocated to issuing instruction
//  rob_commit_signal_in  in   1        ROB commits one entry this cycle
//  rob_commit_tag_in     in   TAG_W    ROB tag of committing entry
//  rob_commit_data_in    in   DATA_W   result value of committing entry
//  rob_commit_target_in  in   REG_IDX_W  destination register of committing entry
//  rob_flush_signal_in   in   1        misprediction flush: discard all renames
// BEHAVIOUR
//  State: data[0..31] (DATA_W), tag[0..31] (TAG_W). Register 0 never written: data 0, tag NULL.
//  Reset (rst=1 at posedge): all data <= 0, all tag <= NULL.
//   Outputs are combinational, so after reset every read returns V=0, Q=NULL.
//   Reset overrides issue, commit and flush in that same cycle.
//  Read (combinational, zero latency), per source port, priority order:
//   1. index == 0 -> V = 0, Q = NULL.
//   2. Commit bypass: rob_commit_signal_in && target == index && tag[index] == rob_commit_tag_in
//      -> V = rob_commit_data_in, Q = NULL.
//   3. Otherwise -> V = data[index], Q = tag[index].
//   Reads see pre-issue state: an instruction's own rd rename is never visible to its own rs1/rs2.
//  Commit (posedge, rob_commit_signal_in=1, target != 0):
//   - data[target] <= rob_commit_data_in, always, even when the tag does not match (later writer
//     still pending; data is overwritten when that writer commits).
//   - tag[target] <= NULL only if tag[target] == rob_commit_tag_in and no higher-priority tag update.
//   - target == 0 -> no effect.
//  Issue (posedge, dec_issue_signal_in=1, rd != 0): tag[rd] <= dec_tag_in. rd == 0 is ignored.
//  Tag-update priority per register, same cycle: flush > issue > commit-clear.
//   - Issue and matching commit on the same rd: tag becomes dec_tag_in; data still written.
//   - Flush: every tag <= NULL. Issue that cycle is dropped.
//     Commit data in the flush cycle is still written (committing instruction is architecturally correct).
//  No backpressure: decoder only issues when the ROB has allocated a tag. Tag reuse safety is the ROB's job.
//  Invariant: at most one commit and one issue per cycle. Tag NULL is never committed.
// TESTING
//  1. Reset, then read rs1=5, rs2=0 -> Vj=0, Qj=0, Vk=0, Qk=0.
//  2. Issue rd=3 tag=2. Next cycle read rs1=3 -> Qj=2.
//     Then commit tag=2 data=0xDEADBEEF target=3: same-cycle read gives Vj=0xDEADBEEF Qj=0;
//     the following cycle gives the same from state.
//  3. Issue rd=4 tag=1, then issue rd=4 tag=5, then commit tag=1 data=7 target=4
//     -> data[4]=7, Qj still 5. Commit tag=5 data=9 -> V=9, Q=0.
//  4. Same cycle: commit tag=6 target=8 data=0x11 and issue rd=8 tag=7
//     -> next cycle rs1=8 gives Qj=7; after commit tag=7 data=0x22, V=0x22.
//  5. Issue rd=0 tag=3; commit target=0 data=0xFF -> rs1=0 reads V=0, Q=0 throughout.
//  6. Pending tags on x1,x2,x9; assert flush with issue rd=10 tag=4 and commit tag=x1's tag data=0x55
//     -> next cycle all Q=NULL, x1 V=0x55, x10 Q=NULL. Reset asserted mid-sequence -> all V=0, Q=NULL.

Source files
------------

// File: rtl/rename_register_file.sv
// Architectural register file with per-register ROB rename tags.
// Serves decoder operands (value or pending tag), records issue renames, and retires ROB commits.
module rename_register_file #(
    parameter int REG_COUNT = 32,
    parameter int REG_IDX_W = 5,
    parameter int TAG_W     = 4,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] dec_rs1_in,
    input  logic [REG_IDX_W-1:0] dec_rs2_in,
    output logic [DATA_W-1:0]    dec_Vj_out,
    output logic [DATA_W-1:0]    dec_Vk_out,
    output logic [TAG_W-1:0]     dec_Qj_out,
    output logic [TAG_W-1:0]     dec_Qk_out,
    input  logic                 dec_issue_signal_in,
    input  logic [REG_IDX_W-1:0] dec_rd_in,
    input  logic [TAG_W-1:0]     dec_tag_in,
    input  logic                 rob_commit_signal_in,
    input  logic [TAG_W-1:0]     rob_commit_tag_in,
    input  logic [DATA_W-1:0]    rob_commit_data_in,
    input  logic [REG_IDX_W-1:0] rob_commit_target_in,
    input  logic                 rob_flush_signal_in
);

    localparam logic [TAG_W-1:0] TAG_NULL = '0;

    logic [DATA_W-1:0] data_reg  [REG_COUNT];
    logic [TAG_W-1:0]  tag_reg   [REG_COUNT];
    logic [DATA_W-1:0] data_next [REG_COUNT];
    logic [TAG_W-1:0]  tag_next  [REG_COUNT];

    logic [REG_IDX_W-1:0] rs_idx [2];
    logic [DATA_W-1:0]    rs_v   [2];
    logic [TAG_W-1:0]     rs_q   [2];

    assign rs_idx[0]  = dec_rs1_in;
    assign rs_idx[1]  = dec_rs2_in;
    assign dec_Vj_out = rs_v[0];
    assign dec_Vk_out = rs_v[1];
    assign dec_Qj_out = rs_q[0];
    assign dec_Qk_out = rs_q[1];

    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign data_next[gi] = '0;
                assign tag_next[gi]  = TAG_NULL;
            end else begin : g_live
                logic commit_hit;
                logic issue_hit;
                assign commit_hit = rob_commit_signal_in &&
                                    (rob_commit_target_in == REG_IDX_W'(gi));
                assign issue_hit  = dec_issue_signal_in && (dec_rd_in == REG_IDX_W'(gi));

                // Data always takes the commit; a still-pending later writer overwrites it on its own commit.
                assign data_next[gi] = commit_hit ? rob_commit_data_in : data_reg[gi];

                // Tag priority: flush, then issue, then clear on a matching commit.
                assign tag_next[gi] = rob_flush_signal_in ? TAG_NULL :
                                      issue_hit ? dec_tag_in :
                                      (commit_hit && (tag_reg[gi] == rob_commit_tag_in)) ? TAG_NULL :
                                      tag_reg[gi];
            end
        end

        for (gi = 0; gi < 2; gi++) begin : g_rd_port
            always_comb begin
                rs_v[gi] = data_reg[rs_idx[gi]];
                rs_q[gi] = tag_reg[rs_idx[gi]];
                if (rs_idx[gi] == '0) begin
                    rs_v[gi] = '0;
                    rs_q[gi] = TAG_NULL;
                end else if (rob_commit_signal_in && (rob_commit_target_in == rs_idx[gi]) &&
                             (tag_reg[rs_idx[gi]] == rob_commit_tag_in)) begin
                    // The producer retires this cycle; forward its result directly.
                    rs_v[gi] = rob_commit_data_in;
                    rs_q[gi] = TAG_NULL;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < REG_COUNT; i++) begin
            if (rst) begin
                data_reg[i] <= '0;
                tag_reg[i]  <= TAG_NULL;
            end else begin
                data_reg[i] <= data_next[i];
                tag_reg[i]  <= tag_next[i];
            end
        end
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Directed bench for rename_register_file: reset, rename, commit bypass, priority, x0 and flush cases.
module tb_rename_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  dec_rs1_in, dec_rs2_in, dec_rd_in, rob_commit_target_in;
    logic [31:0] dec_Vj_out, dec_Vk_out, rob_commit_data_in;
    logic [3:0]  dec_Qj_out, dec_Qk_out, dec_tag_in, rob_commit_tag_in;
    logic        dec_issue_signal_in, rob_commit_signal_in, rob_flush_signal_in;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    rename_register_file dut (
        .clk                  (clk),
        .rst                  (rst),
        .dec_rs1_in           (dec_rs1_in),
        .dec_rs2_in           (dec_rs2_in),
        .dec_Vj_out           (dec_Vj_out),
        .dec_Vk_out           (dec_Vk_out),
        .dec_Qj_out           (dec_Qj_out),
        .dec_Qk_out           (dec_Qk_out),
        .dec_issue_signal_in  (dec_issue_signal_in),
        .dec_rd_in            (dec_rd_in),
        .dec_tag_in           (dec_tag_in),
        .rob_commit_signal_in (rob_commit_signal_in),
        .rob_commit_tag_in    (rob_commit_tag_in),
        .rob_commit_data_in   (rob_commit_data_in),
        .rob_commit_target_in (rob_commit_target_in),
        .rob_flush_signal_in  (rob_flush_signal_in)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Advance one clock; inputs change #1 after the edge, away from sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_issue_signal_in  = 1'b0;
        rob_commit_signal_in = 1'b0;
        rob_flush_signal_in  = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] tg);
        dec_issue_signal_in = 1'b1;
        dec_rd_in           = rd;
        dec_tag_in          = tg;
    endtask

    task automatic commit(input logic [3:0] tg, input logic [31:0] d, input logic [4:0] tgt);
        rob_commit_signal_in = 1'b1;
        rob_commit_tag_in    = tg;
        rob_commit_data_in   = d;
        rob_commit_target_in = tgt;
    endtask

    task automatic rd2(input logic [4:0] a, input logic [4:0] b);
        dec_rs1_in = a;
        dec_rs2_in = b;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        dec_rd_in = '0; dec_tag_in = '0; rob_commit_tag_in = '0;
        rob_commit_data_in = '0; rob_commit_target_in = '0;
        dec_rs1_in = '0; dec_rs2_in = '0;
        tick(); tick();
        rst = 1'b0;

        // 1. reset state
        rd2(5'd5, 5'd0);
        check("rst_vj", dec_Vj_out, 32'h0);
        check("rst_qj", 32'(dec_Qj_out), 32'h0);
        check("rst_vk", dec_Vk_out, 32'h0);
        check("rst_qk", 32'(dec_Qk_out), 32'h0);

        // 2. rename then commit with bypass
        issue(5'd3, 4'd2); tick(); idle();
        rd2(5'd3, 5'd3);
        check("t2_qj_pending", 32'(dec_Qj_out), 32'd2);
        check("t2_qk_pending", 32'(dec_Qk_out), 32'd2);
        commit(4'd2, 32'hDEADBEEF, 5'd3); #1;
        check("t2_byp_vj", dec_Vj_out, 32'hDEADBEEF);
        check("t2_byp_qj", 32'(dec_Qj_out), 32'd0);
        tick(); idle(); #1;
        check("t2_st_vj", dec_Vj_out, 32'hDEADBEEF);
        check("t2_st_qk", 32'(dec_Qk_out), 32'd0);

        // 3. stale commit writes data but leaves newer tag
        issue(5'd4, 4'd1); tick();
        issue(5'd4, 4'd5); tick(); idle();
        commit(4'd1, 32'd7, 5'd4); rd2(5'd4, 5'd0);
        check("t3_nobyp_vj", dec_Vj_out, 32'd0);
        check("t3_nobyp_qj", 32'(dec_Qj_out), 32'd5);
        tick(); idle(); #1;
        check("t3_stale_vj", dec_Vj_out, 32'd7);
        check("t3_stale_qj", 32'(dec_Qj_out), 32'd5);
        commit(4'd5, 32'd9, 5'd4); tick(); idle(); #1;
        check("t3_final_vj", dec_Vj_out, 32'd9);
        check("t3_final_qj", 32'(dec_Qj_out), 32'd0);

        // 4. issue beats commit-clear on the same register
        commit(4'd6, 32'h11, 5'd8); issue(5'd8, 4'd7); tick(); idle();
        rd2(5'd8, 5'd4);
        check("t4_qj", 32'(dec_Qj_out), 32'd7);
        check("t4_vj", dec_Vj_out, 32'h11);
        check("t4_vk", dec_Vk_out, 32'd9);
        commit(4'd7, 32'h22, 5'd8); tick(); idle(); #1;
        check("t4_final_vj", dec_Vj_out, 32'h22);
        check("t4_final_qj", 32'(dec_Qj_out), 32'd0);

        // 5. x0 ignores issue and commit
        issue(5'd0, 4'd3); commit(4'd3, 32'hFF, 5'd0); rd2(5'd0, 5'd0);
        check("t5_byp_vj", dec_Vj_out, 32'd0);
        check("t5_byp_qj", 32'(dec_Qj_out), 32'd0);
        tick(); idle(); #1;
        check("t5_vj", dec_Vj_out, 32'd0);
        check("t5_qk", 32'(dec_Qk_out), 32'd0);

        // 6. flush clears tags, drops issue, keeps commit data
        issue(5'd1, 4'd8); tick();
        issue(5'd2, 4'd9); tick();
        issue(5'd9, 4'd10); tick(); idle();
        rd2(5'd1, 5'd2);
        check("t6_pre_q1", 32'(dec_Qj_out), 32'd8);
        check("t6_pre_q2", 32'(dec_Qk_out), 32'd9);
        rob_flush_signal_in = 1'b1; issue(5'd10, 4'd4); commit(4'd8, 32'h55, 5'd1);
        tick(); idle();
        rd2(5'd1, 5'd2);
        check("t6_x1_v", dec_Vj_out, 32'h55);
        check("t6_x1_q", 32'(dec_Qj_out), 32'd0);
        check("t6_x2_q", 32'(dec_Qk_out), 32'd0);
        rd2(5'd9, 5'd10);
        check("t6_x9_q", 32'(dec_Qj_out), 32'd0);
        check("t6_x10_q", 32'(dec_Qk_out), 32'd0);

        // reset mid-sequence overrides issue and commit
        issue(5'd5, 4'd11); tick(); idle();
        rd2(5'd5, 5'd3);
        check("t6_x5_q_pre", 32'(dec_Qj_out), 32'd11);
        check("t6_x3_v_pre", dec_Vk_out, 32'hDEADBEEF);
        rst = 1'b1; commit(4'd0, 32'h77, 5'd6); issue(5'd7, 4'd12);
        tick(); rst = 1'b0; idle();
        rd2(5'd5, 5'd3);
        check("rst2_x5_q", 32'(dec_Qj_out), 32'd0);
        check("rst2_x3_v", dec_Vk_out, 32'd0);
        rd2(5'd1, 5'd6);
        check("rst2_x1_v", dec_Vj_out, 32'd0);
        check("rst2_x6_v", dec_Vk_out, 32'd0);
        rd2(5'd7, 5'd4);
        check("rst2_x7_q", 32'(dec_Qj_out), 32'd0);
        check("rst2_x4_v", dec_Vk_out, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
